// File: rtl/bus_data_sync.sv
// rtl/bus_data_sync.sv - enable-qualified bus synchronizer with pulse generation; BUS_DATA_SYNC_TOGGLE_EN selects toggle-mode enable
module bus_data_sync #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE
);

    // Reject illegal configurations at elaboration time
    if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_stages
        $error("bus_data_sync: NUM_STAGES must be in 2..8");
    end
    if (BUS_WIDTH < 1 || BUS_WIDTH > 32) begin : g_bad_width
        $error("bus_data_sync: BUS_WIDTH must be in 1..32");
    end

    logic [NUM_STAGES-1:0] sync_q;
    logic                  sync_out;
    logic                  pg_ff;
    logic                  pulse_c;

    assign sync_out = sync_q[NUM_STAGES-1];

    // Only the enable crosses through the flop chain; the bus is captured
    // once the synchronized enable proves it has been stable for a while.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], BUS_ENABLE};
        end
    end

    // Delayed copy of the synchronized enable for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pg_ff <= 1'b0;
        end else begin
            pg_ff <= sync_out;
        end
    end

    // Rising edge in level mode, any edge in toggle mode
    always_comb begin
        pulse_c = 1'b0;
`ifdef BUS_DATA_SYNC_TOGGLE_EN
        pulse_c = sync_out ^ pg_ff;
`else
        pulse_c = sync_out & ~pg_ff;
`endif
    end

    // Registered strobe and bus capture; the bus is only sampled on a pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ENABLE_PULSE <= 1'b0;
            SYNC_BUS     <= '0;
        end else begin
            ENABLE_PULSE <= pulse_c;
            if (pulse_c) begin
                SYNC_BUS <= UNSYNC_BUS;
            end
        end
    end

endmodule

// File: tb/tb_bus_data_sync.sv
// tb/tb_bus_data_sync.sv - randomized self-checking bench for bus_data_sync
module tb_bus_data_sync;

    localparam int NS = 2;
    localparam int BW = 8;
`ifdef BUS_DATA_SYNC_TOGGLE_EN
    localparam int TWO_XFER_PULSES = 4;
`else
    localparam int TWO_XFER_PULSES = 2;
`endif

    logic          clk;
    logic          rst;
    logic [BW-1:0] unsync_bus;
    logic          bus_enable;
    logic [BW-1:0] sync_bus;
    logic          enable_pulse;

    int vectors;
    int miscompares;
    int pulse_cnt;

    bit            hist[$];
    logic [BW-1:0] exp_bus;
    logic          exp_pulse;

    bus_data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW)) dut (
        .CLK          (clk),
        .RST          (rst),
        .UNSYNC_BUS   (unsync_bus),
        .BUS_ENABLE   (bus_enable),
        .SYNC_BUS     (sync_bus),
        .ENABLE_PULSE (enable_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Enable value sampled at post-reset edge j (1-based); zero before the first edge
    function automatic bit en_at(int j);
        if (j < 1 || j > hist.size()) return 1'b0;
        return hist[j-1];
    endfunction

    // Reference: pulse after edge t depends on the enable samples at t-NS and t-NS-1
    always @(posedge clk) begin
        bit cur, prev, p;
        int t;
        if (rst) begin
            hist.delete();
            exp_bus   = '0;
            exp_pulse = 1'b0;
        end else begin
            hist.push_back(bus_enable);
            t    = hist.size();
            cur  = en_at(t - NS);
            prev = en_at(t - NS - 1);
`ifdef BUS_DATA_SYNC_TOGGLE_EN
            p = cur ^ prev;
`else
            p = cur & ~prev;
`endif
            exp_pulse = p;
            if (p) exp_bus = unsync_bus;
        end
        #1;
        check_eq("enable_pulse", 32'(enable_pulse), 32'(exp_pulse));
        check_eq("sync_bus", 32'(sync_bus), 32'(exp_bus));
        if (enable_pulse === 1'b1) pulse_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        vectors     = 0;
        miscompares = 0;
        pulse_cnt   = 0;
        rst         = 1'b1;
        unsync_bus  = 8'hA5;
        bus_enable  = 1'b1;

        // Reset held with enable high, then released
        cycles(5);
        base = pulse_cnt;
        rst  = 1'b0;
        cycles(6);
        check_eq("rst_release_pulses", 32'(pulse_cnt - base), 32'd1);
        check_eq("rst_release_bus", 32'(sync_bus), 32'hA5);
        bus_enable = 1'b0;
        cycles(5);

        // Long held enable gives a single pulse
        base       = pulse_cnt;
        unsync_bus = 8'h3C;
        bus_enable = 1'b1;
        cycles(10);
        check_eq("held_pulses", 32'(pulse_cnt - base), 32'd1);
        check_eq("held_bus", 32'(sync_bus), 32'h3C);
        bus_enable = 1'b0;
        cycles(5);

        // Two back-to-back transfers
        base       = pulse_cnt;
        unsync_bus = 8'h11;
        bus_enable = 1'b1;
        cycles(3);
        bus_enable = 1'b0;
        cycles(1);
        unsync_bus = 8'h22;
        bus_enable = 1'b1;
        cycles(3);
        bus_enable = 1'b0;
        cycles(6);
        check_eq("two_xfer_pulses", 32'(pulse_cnt - base), 32'(TWO_XFER_PULSES));
        check_eq("two_xfer_bus", 32'(sync_bus), 32'h22);

        // Bus churn with enable low must not leak through
        base = pulse_cnt;
        for (int i = 0; i < 20; i++) begin
            unsync_bus = BW'($urandom);
            cycles(1);
        end
        check_eq("idle_pulses", 32'(pulse_cnt - base), 32'd0);
        check_eq("idle_bus", 32'(sync_bus), 32'h22);

        // Reset between enable rise and expected pulse
        unsync_bus = 8'h5A;
        bus_enable = 1'b1;
        cycles(1);
        rst = 1'b1;
        cycles(1);
        check_eq("abort_bus", 32'(sync_bus), 32'h0);
        base = pulse_cnt;
        rst  = 1'b0;
        cycles(5);
        check_eq("abort_rerun_pulses", 32'(pulse_cnt - base), 32'd1);
        check_eq("abort_rerun_bus", 32'(sync_bus), 32'h5A);
        bus_enable = 1'b0;
        cycles(5);

        // Randomized transfers with occasional resets
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                cycles($urandom_range(1, 3));
                rst = 1'b0;
            end
            unsync_bus = BW'($urandom);
            bus_enable = ~bus_enable;
            cycles($urandom_range(NS + 1, NS + 4));
        end
        bus_enable = 1'b0;
        cycles(NS + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
